// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, counter width and parameter check for sram_ctrl
package sram_pkg;
  localparam int WAIT_W = 4;
  typedef enum logic [2:0] {IDLE, RD, TURN, WSETUP, WPULSE, WHOLD} state_t;
  function automatic bit params_ok(int dw, int rd_wait, int wr_wait, int turnaround);
    return dw > 0 && dw % 8 == 0 && rd_wait inside {[0:15]} && wr_wait inside {[0:15]} &&
           turnaround inside {[0:15]};
  endfunction
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-clock asynchronous-SRAM controller with valid/ready request port
module sram_ctrl import sram_pkg::*; #(
  parameter int AW = 19,
  parameter int DW = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int TURNAROUND = 1
) (
  input  logic            clk_core,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic [AW-1:0]   sram_a,
  output logic [DW-1:0]   sram_d_out,
  input  logic [DW-1:0]   sram_d_in,
  output logic            sram_d_oe,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic [DW/8-1:0] sram_be_n
);
  localparam int BW = DW / 8;
  localparam logic [WAIT_W-1:0] RD_LD = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_LD = WAIT_W'(WR_WAIT);
  localparam logic [WAIT_W-1:0] TA_LD = WAIT_W'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);
  if (!params_ok(DW, RD_WAIT, WR_WAIT, TURNAROUND)) begin : g_param_err
    $error("sram_ctrl: DW must be a multiple of 8 and wait/turnaround values must be 0..15");
  end
  state_t state, next;
  logic [WAIT_W-1:0] cnt, cnt_d;
  logic [BW-1:0] be_q, be_n_d;
  logic [DW-1:0] wdata_q;
  logic last_rd, accept, done, rd_done;
  logic ce_n_d, oe_n_d, we_n_d, d_oe_d;
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign done = cnt == '0;
  assign rd_done = state == RD && done;
  always_ff @(posedge clk_core) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= cnt_d;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = !req_we ? RD : (last_rd && TURNAROUND > 0) ? TURN : WSETUP;
      RD:      if (done) next = IDLE;
      TURN:    if (done) next = WSETUP;
      WSETUP:  next = WPULSE;
      WPULSE:  if (done) next = WHOLD;
      WHOLD:   next = IDLE;
      default: next = IDLE;
    endcase
  end
  // Strobes are registered, so decode them from the state being entered.
  always_comb begin
    ce_n_d = next inside {IDLE, TURN};
    oe_n_d = next != RD;
    we_n_d = next != WPULSE;
    d_oe_d = next inside {WSETUP, WPULSE, WHOLD};
    be_n_d = ce_n_d ? '1 : ~(accept ? req_be : be_q);
    cnt_d = next == state ? cnt - 1'b1 :
            next == RD ? RD_LD : next == TURN ? TA_LD : next == WPULSE ? WR_LD : '0;
  end
  always_ff @(posedge clk_core) begin
    if (reset) begin
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      sram_d_oe <= 1'b0;
      sram_a <= '0;
      sram_d_out <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      last_rd <= 1'b0;
      be_q <= '0;
      wdata_q <= '0;
    end else begin
      sram_ce_n <= ce_n_d;
      sram_oe_n <= oe_n_d;
      sram_we_n <= we_n_d;
      sram_be_n <= be_n_d;
      sram_d_oe <= d_oe_d;
      rsp_valid <= rd_done || state == WHOLD;
      if (accept) begin
        sram_a <= req_addr;
        be_q <= req_be;
        wdata_q <= req_wdata;
      end
      if (next == WSETUP) sram_d_out <= accept ? req_wdata : wdata_q;
      if (rd_done) rsp_rdata <= sram_d_in;
      if (rd_done) last_rd <= 1'b1;
      else if (state == WHOLD) last_rd <= 1'b0;
    end
  end
endmodule
